// File: rtl/uk101_pkg.sv
// Shared UK101 definitions: load-FIFO state encoding, ASCII control codes
// and the gap-counter load helper.
package uk101_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_PRESENT,
      ST_GAP,
      ST_DRAIN
   } load_state_t;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

   // A requested gap of N cycles loads N-1; zero still yields one gap cycle.
   function automatic int unsigned gap_load(input int unsigned cycles);
      return (cycles == 32'd0) ? 32'd0 : cycles - 32'd1;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Byte FIFO with power-of-two depth. Flush empties it and may accept that
// cycle's push as the first entry of the new contents.
module sync_fifo #(
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     n_reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [7:0]               wr_data,
   output logic [7:0]               rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_idx;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && (!full || flush);
   assign do_pop  = pop && !empty && !flush;
   assign wr_idx  = flush ? '0 : wr_ptr;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (n_reset && do_push) begin
         mem[wr_idx] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= do_push ? AW'(1) : '0;
         count  <= do_push ? CW'(1) : '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop) begin
            count <= count + CW'(1);
         end else if (do_pop && !do_push) begin
            count <= count - CW'(1);
         end
      end
   end

endmodule

// File: rtl/ascii_load_fifo.sv
// Paces an HPS file download into the ACIA receive path one byte at a time,
// with a short idle gap per byte and a long one after each carriage return.
module ascii_load_fifo
   import uk101_pkg::*;
#(
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned GAP_CYCLES = 48000,
   parameter int unsigned LINE_GAP   = 960000,
   parameter int unsigned STRIP_LF   = 1
) (
   input  logic        clk,
   input  logic        n_reset,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [15:0] ioctl_addr,
   input  logic [7:0]  ioctl_data,
   output logic        ioctl_wait,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   input  logic        rx_ready,
   output logic        busy,
   output logic        overflow
);

   localparam int CW      = $clog2(DEPTH) + 1;
   localparam int GAP_MAX = (GAP_CYCLES > LINE_GAP) ? int'(GAP_CYCLES) : int'(LINE_GAP);
   localparam int GW      = ($clog2(GAP_MAX + 1) > 0) ? $clog2(GAP_MAX + 1) : 1;

   localparam logic [GW-1:0] BYTE_LOAD  = GW'(gap_load(GAP_CYCLES));
   localparam logic [GW-1:0] LINE_LOAD  = GW'(gap_load(LINE_GAP));
   localparam logic [CW-1:0] WAIT_LEVEL = CW'(DEPTH - 1);

   load_state_t   state;
   logic [GW-1:0] gap_cnt;
   logic          download_q;
   logic          is_rise;
   logic          new_file;
   logic          wr_valid;
   logic          is_lf;
   logic          push;
   logic          pop;
   logic          drop;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;
   logic [7:0]    head;

   // A new file starts on the download rise or on a write to offset 0;
   // writes outside a download are ignored, so the restart needs one too.
   assign is_rise  = ioctl_download && !download_q;
   assign wr_valid = ioctl_wr && ioctl_download;
   assign new_file = is_rise || (wr_valid && (ioctl_addr == 16'h0000));
   assign is_lf    = (STRIP_LF != 0) && (ioctl_data == ASCII_LF);
   assign push     = wr_valid && !is_lf && (!fifo_full || new_file);
   assign drop     = wr_valid && fifo_full && !new_file;
   assign pop      = (state == ST_PRESENT) && rx_ready && !new_file;

   sync_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .n_reset (n_reset),
      .push    (push),
      .pop     (pop),
      .flush   (new_file),
      .wr_data (ioctl_data),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         state      <= ST_IDLE;
         gap_cnt    <= '0;
         download_q <= 1'b0;
         ioctl_wait <= 1'b0;
         rx_data    <= 8'h00;
         rx_valid   <= 1'b0;
         busy       <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         download_q <= ioctl_download;
         ioctl_wait <= (fifo_count >= WAIT_LEVEL);
         if (new_file) begin
            overflow <= 1'b0;
         end else if (drop) begin
            overflow <= 1'b1;
         end

         if (new_file) begin
            state    <= ST_FILL;
            rx_valid <= 1'b0;
            busy     <= 1'b1;
         end else begin
            case (state)
               ST_IDLE: begin
                  busy <= 1'b0;
               end
               ST_FILL: begin
                  if (!fifo_empty) begin
                     state    <= ST_PRESENT;
                     rx_valid <= 1'b1;
                     rx_data  <= head;
                  end else if (!ioctl_download) begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end
               end
               ST_PRESENT: begin
                  if (rx_ready) begin
                     gap_cnt  <= (rx_data == ASCII_CR) ? LINE_LOAD : BYTE_LOAD;
                     rx_valid <= 1'b0;
                     state    <= ioctl_download ? ST_GAP : ST_DRAIN;
                  end
               end
               ST_GAP, ST_DRAIN: begin
                  // A download that ends mid-gap still waits out that gap.
                  if (gap_cnt != '0) begin
                     gap_cnt <= gap_cnt - GW'(1);
                  end else if (!fifo_empty) begin
                     state    <= ST_PRESENT;
                     rx_valid <= 1'b1;
                     rx_data  <= head;
                  end else if ((state == ST_GAP) && ioctl_download) begin
                     state <= ST_FILL;
                  end else begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end
               end
               default: begin
                  state    <= ST_IDLE;
                  rx_valid <= 1'b0;
                  busy     <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ascii_load_fifo.sv
// Scoreboard bench: one DUT strips LF, a twin keeps it; both share stimulus.
module tb_ascii_load_fifo;

   localparam int unsigned DEPTH      = 4;
   localparam int unsigned GAP_CYCLES = 4;
   localparam int unsigned LINE_GAP   = 10;
   localparam logic [7:0]  LF_BYTE    = 8'h0A;
   localparam logic [7:0]  CR_BYTE    = 8'h0D;

   logic        clk = 1'b0;
   logic        n_reset;
   logic        ioctl_download;
   logic        ioctl_wr;
   logic [15:0] ioctl_addr;
   logic [7:0]  ioctl_data;
   logic        rx_ready;

   logic        ioctl_wait0, rx_valid0, busy0, overflow0;
   logic [7:0]  rx_data0;
   logic        ioctl_wait1, rx_valid1, busy1, overflow1;
   logic [7:0]  rx_data1;

   logic [7:0] exp_q0[$];
   logic [7:0] exp_q1[$];
   int         cons_q[$];
   int         extra0, extra1;
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;

   ascii_load_fifo #(.DEPTH(DEPTH), .GAP_CYCLES(GAP_CYCLES), .LINE_GAP(LINE_GAP), .STRIP_LF(1)) dut0 (
      .clk(clk), .n_reset(n_reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
      .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wait(ioctl_wait0),
      .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rx_ready), .busy(busy0),
      .overflow(overflow0)
   );

   ascii_load_fifo #(.DEPTH(DEPTH), .GAP_CYCLES(GAP_CYCLES), .LINE_GAP(LINE_GAP), .STRIP_LF(0)) dut1 (
      .clk(clk), .n_reset(n_reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
      .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wait(ioctl_wait1),
      .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ready(rx_ready), .busy(busy1),
      .overflow(overflow1)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      n_reset = 1'b0; ioctl_wr = 1'b0; ioctl_download = 1'b0; rx_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_reset = 1'b1;
      exp_q0.delete(); exp_q1.delete(); cons_q.delete();
      extra0 = 0; extra1 = 0;
   endtask

   // driver tasks
   task automatic wr_byte(input logic [15:0] addr, input logic [7:0] data, input bit keep);
      @(negedge clk);
      ioctl_wr = 1'b1; ioctl_addr = addr; ioctl_data = data;
      if (addr == 16'h0000) begin
         exp_q0.delete(); exp_q1.delete();
      end
      if (keep) begin
         if (data != LF_BYTE) exp_q0.push_back(data);
         exp_q1.push_back(data);
      end
   endtask

   task automatic wr_end();
      @(negedge clk);
      ioctl_wr = 1'b0;
   endtask

   task automatic steps(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 400) begin
         @(negedge clk);
         n++;
      end
      check_eq({tag, "_left0"}, 32'(exp_q0.size()), 32'd0);
      check_eq({tag, "_left1"}, 32'(exp_q1.size()), 32'd0);
   endtask

   task automatic wait_idle(input string tag, output int fall);
      int n = 0;
      while (busy0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      fall = cyc;
      check_eq({tag, "_idle"}, 32'(busy0), 32'd0);
   endtask

   // scoreboard: a byte is consumed when rx_valid and rx_ready meet at an edge
   always begin
      @(negedge clk);
      #3;
      if (n_reset && rx_valid0 && rx_ready) begin
         cons_q.push_back(cyc);
         if (exp_q0.size() == 0) extra0++;
         else check_eq("rx_data0", 32'(rx_data0), 32'(exp_q0.pop_front()));
      end
      if (n_reset && rx_valid1 && rx_ready) begin
         if (exp_q1.size() == 0) extra1++;
         else check_eq("rx_data1", 32'(rx_data1), 32'(exp_q1.pop_front()));
      end
   end

   initial begin
      int fall;
      n_reset = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
      ioctl_addr = '0; ioctl_data = '0; rx_ready = 1'b0;

      // reset state
      do_reset();
      check_eq("rst_valid", 32'(rx_valid0), 32'd0);
      check_eq("rst_data", 32'(rx_data0), 32'd0);
      check_eq("rst_busy", 32'(busy0), 32'd0);
      check_eq("rst_wait", 32'(ioctl_wait0), 32'd0);
      check_eq("rst_ovf", 32'(overflow0), 32'd0);

      // 'A','B',CR with immediate acknowledge; measure byte and line gaps
      rx_ready = 1'b1;
      ioctl_download = 1'b1;
      wr_byte(16'd0, 8'h41, 1'b1);
      wr_byte(16'd1, 8'h42, 1'b1);
      wr_byte(16'd2, CR_BYTE, 1'b1);
      wr_end();
      ioctl_download = 1'b0;
      wait_drain("abc");
      check_eq("abc_busy_after_cr", 32'(busy0), 32'd1);
      wait_idle("abc", fall);
      check_eq("abc_count", 32'(cons_q.size()), 32'd3);
      if (cons_q.size() == 3) begin
         check_eq("gap_ab", 32'(cons_q[1] - cons_q[0]), 32'(GAP_CYCLES + 1));
         check_eq("gap_bcr", 32'(cons_q[2] - cons_q[1]), 32'(GAP_CYCLES + 1));
         check_eq("busy_hold", 32'(fall - cons_q[2]), 32'(LINE_GAP + 1));
      end
      check_eq("abc_extra0", 32'(extra0), 32'd0);

      // LF stripped by dut0, kept by dut1
      do_reset();
      rx_ready = 1'b1;
      ioctl_download = 1'b1;
      wr_byte(16'd0, 8'h58, 1'b1);
      wr_byte(16'd1, LF_BYTE, 1'b1);
      wr_byte(16'd2, 8'h59, 1'b1);
      wr_end();
      ioctl_download = 1'b0;
      wait_drain("lf");
      wait_idle("lf", fall);
      check_eq("lf_extra0", 32'(extra0), 32'd0);
      check_eq("lf_extra1", 32'(extra1), 32'd0);

      // overflow: six back-to-back writes, no acknowledge
      do_reset();
      ioctl_download = 1'b1;
      for (int i = 0; i < 6; i++) begin
         wr_byte(16'(i), 8'(8'h30 + i), i < 4);
         if (i == 2) check_eq("ovf_wait_early", 32'(ioctl_wait0), 32'd0);
         if (i == 4) check_eq("ovf_wait_set", 32'(ioctl_wait0), 32'd1);
      end
      wr_end();
      check_eq("ovf_flag", 32'(overflow0), 32'd1);
      check_eq("ovf_wait_full", 32'(ioctl_wait0), 32'd1);
      ioctl_download = 1'b0;
      rx_ready = 1'b1;
      wait_drain("ovf");
      wait_idle("ovf", fall);
      check_eq("ovf_extra0", 32'(extra0), 32'd0);
      check_eq("ovf_wait_clear", 32'(ioctl_wait0), 32'd0);
      check_eq("ovf_sticky", 32'(overflow0), 32'd1);

      // second download flushes queued bytes and clears overflow
      do_reset();
      ioctl_download = 1'b1;
      for (int i = 0; i < 5; i++) wr_byte(16'(i), 8'(8'h40 + i), i < 4);
      wr_end();
      check_eq("new_ovf_set", 32'(overflow0), 32'd1);
      ioctl_download = 1'b0;
      steps(1);
      ioctl_download = 1'b1;
      wr_byte(16'd0, 8'h60, 1'b1);
      wr_byte(16'd1, 8'h61, 1'b1);
      wr_end();
      check_eq("new_ovf_clr", 32'(overflow0), 32'd0);
      ioctl_download = 1'b0;
      rx_ready = 1'b1;
      wait_drain("new");
      wait_idle("new", fall);
      check_eq("new_extra0", 32'(extra0), 32'd0);

      // reset pulse while presenting with three bytes queued
      do_reset();
      ioctl_download = 1'b1;
      for (int i = 0; i < 3; i++) wr_byte(16'(i), 8'(8'h50 + i), 1'b1);
      wr_end();
      steps(2);
      check_eq("rp_valid_pre", 32'(rx_valid0), 32'd1);
      check_eq("rp_wait_pre", 32'(ioctl_wait0), 32'd1);
      @(negedge clk);
      n_reset = 1'b0; ioctl_download = 1'b0;
      @(negedge clk);
      n_reset = 1'b1;
      exp_q0.delete(); exp_q1.delete();
      check_eq("rp_valid", 32'(rx_valid0), 32'd0);
      check_eq("rp_busy", 32'(busy0), 32'd0);
      check_eq("rp_wait", 32'(ioctl_wait0), 32'd0);
      rx_ready = 1'b1;
      steps(30);
      check_eq("rp_extra0", 32'(extra0), 32'd0);
      check_eq("rp_busy_late", 32'(busy0), 32'd0);

      // simultaneous push and pop at occupancy 2
      do_reset();
      ioctl_download = 1'b1;
      wr_byte(16'd0, 8'h70, 1'b1);
      wr_byte(16'd1, 8'h71, 1'b1);
      wr_end();
      steps(2);
      check_eq("pp_count_pre", 32'(dut0.u_fifo.count), 32'd2);
      check_eq("pp_valid_pre", 32'(rx_valid0), 32'd1);
      wr_byte(16'd2, 8'h72, 1'b1);
      rx_ready = 1'b1;
      @(negedge clk);
      ioctl_wr = 1'b0;
      rx_ready = 1'b0;
      check_eq("pp_count", 32'(dut0.u_fifo.count), 32'd2);
      check_eq("pp_wait", 32'(ioctl_wait0), 32'd0);
      steps(1);
      check_eq("pp_wait_next", 32'(ioctl_wait0), 32'd0);
      ioctl_download = 1'b0;
      rx_ready = 1'b1;
      wait_drain("pp");
      wait_idle("pp", fall);
      check_eq("pp_extra0", 32'(extra0), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
